// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit:
//   INST_WIDTH        - instruction word width
//   PC_STEP           - byte distance between consecutive instructions
//   DEFAULT_RESET_PC  - default address of the first fetch after reset
//   COUNT_MAX         - saturation value of the optional perf counters
//   fetch_state_t     - FSM encoding (RUN / HOLD / DONE)
//   align_pc()        - clears the sub-word bits of a redirect target
//   sat_inc()         - saturating 32-bit increment
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int unsigned INST_WIDTH       = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] COUNT_MAX        = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RUN  = 2'd0,  // fetching whenever the output register can accept
        HOLD = 2'd1,  // output register full and decode not accepting
        DONE = 2'd2   // program end reached, draining the last instruction
    } fetch_state_t;

    // Redirect targets are forced onto an instruction boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~(PC_STEP - 32'd1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == COUNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter register with increment, redirect and hold mux.
// Ports:
//   clk            - clock, rising edge
//   rst_n          - synchronous active-low reset, loads RESET_PC
//   redirect       - load the aligned redirect_addr (wins over advance)
//   redirect_addr  - redirect target, low bits ignored
//   advance        - step the PC by PC_STEP
//   pc             - current PC
//   pc_plus        - pc + PC_STEP, modulo 2^32
// With neither redirect nor advance the PC holds.
// -----------------------------------------------------------------------------
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        advance,
    output logic [31:0] pc,
    output logic [31:0] pc_plus
);

    // 32-bit addition drops the carry, so 32'hFFFFFFFC steps to 32'h00000000.
    assign pc_plus = pc + PC_STEP;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= align_pc(redirect_addr);
        end else if (advance) begin
            pc <= pc_plus;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: drives the instruction memory address from the PC,
// captures the returned word into an output register and hands it to decode
// with a valid/ready handshake. Fetching stops once the PC reaches PROG_END;
// a branch redirect flushes the output register and restarts fetching.
//
// Parameters:
//   RESET_PC  - address of the first fetch after reset
//   PROG_END  - first address past the program
// Ports:
//   clk            - clock, rising edge
//   rst_n          - synchronous active-low reset
//   Freeze         - hazard stall, holds PC, state and outputs
//   BranchTaken    - redirect request from a later stage
//   BranchAddr     - redirect target
//   Address        - instruction memory address (the PC)
//   Instruction    - instruction memory read data for Address
//   IF_Valid       - IF_Instruction / IF_PC hold a live instruction
//   ID_Ready       - decode accepts; transfer when IF_Valid && ID_Ready
//   IF_Instruction - registered fetched instruction
//   IF_PC          - registered address of that instruction plus 4
//   Done           - high in state DONE
// Optional build macro FETCH_PERF_EN adds:
//   FetchCount     - completed transfers, saturating
//   StallCount     - cycles in HOLD or with Freeze high, saturating
// Priority: reset > BranchTaken > Freeze > handshake/advance.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PROG_END = 32'h0000_001C
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Freeze,
    input  logic                  BranchTaken,
    input  logic [31:0]           BranchAddr,
    output logic [31:0]           Address,
    input  logic [INST_WIDTH-1:0] Instruction,
    output logic                  IF_Valid,
    input  logic                  ID_Ready,
    output logic [INST_WIDTH-1:0] IF_Instruction,
    output logic [31:0]           IF_PC,
    output logic                  Done
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           FetchCount,
    output logic [31:0]           StallCount
`endif
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        load;         // capture Instruction and advance the PC
    logic        clear_valid;  // drop the output register contents
    logic        transfer;     // decode takes the current output this cycle

    assign transfer = IF_Valid && ID_Ready;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect      (BranchTaken),
        .redirect_addr (BranchAddr),
        .advance       (load),
        .pc            (pc),
        .pc_plus       (pc_plus)
    );

    assign Address = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        load        = 1'b0;
        clear_valid = 1'b0;
        Done        = (state == DONE);

        if (BranchTaken) begin
            // Flush: the word at the old PC is never captured.
            state_next  = RUN;
            clear_valid = 1'b1;
        end else if (!Freeze) begin
            unique case (state)
                RUN, HOLD: begin
                    // In HOLD IF_Valid is always set, so the same test covers
                    // both waiting for ID_Ready and the cycle it rises.
                    if (!IF_Valid || ID_Ready) begin
                        load       = 1'b1;
                        state_next = (pc_plus == PROG_END) ? DONE : RUN;
                    end else begin
                        state_next = HOLD;
                    end
                end
                DONE: begin
                    if (transfer) begin
                        clear_valid = 1'b1;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // NOTE: the output register is reset explicitly because its contents are
    // visible at the ports; the bare data fields would otherwise power up as X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            IF_Valid       <= 1'b0;
            IF_Instruction <= '0;
            IF_PC          <= '0;
        end else if (clear_valid) begin
            IF_Valid <= 1'b0;
        end else if (load) begin
            IF_Valid       <= 1'b1;
            IF_Instruction <= Instruction;
            IF_PC          <= pc_plus;
        end
    end

`ifdef FETCH_PERF_EN
    // A transfer completes only when the output register actually drains:
    // a frozen or flushed cycle re-presents or discards the word instead.
    logic fetch_event;
    logic stall_event;

    assign fetch_event = transfer && !Freeze && !BranchTaken;
    assign stall_event = (state == HOLD) || Freeze;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            FetchCount <= '0;
            StallCount <= '0;
        end else begin
            if (fetch_event) begin
                FetchCount <= sat_inc(FetchCount);
            end
            if (stall_event) begin
                StallCount <= sat_inc(StallCount);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A behavioural model of the fetch rules
// runs alongside the DUT and is compared on every falling edge; directed
// sequences add hand-computed literal expectations. A second instance with
// PROG_END = 0 covers the wrap-into-DONE case. Define FETCH_PERF_EN to also
// exercise the performance counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] PROG_END = 32'h0000_001C;

    logic        clk;
    logic        rst_n;
    logic        Freeze;
    logic        BranchTaken;
    logic [31:0] BranchAddr;
    logic        ID_Ready;

    logic [31:0] Address;
    logic [31:0] Instruction;
    logic        IF_Valid;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC;
    logic        Done;

    logic [31:0] Address2;
    logic [31:0] Instruction2;
    logic        IF_Valid2;
    logic [31:0] IF_Instruction2;
    logic [31:0] IF_PC2;
    logic        Done2;

`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
    logic [31:0] FetchCount2;
    logic [31:0] StallCount2;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    logic [31:0] xfer_log[$];

    // Instruction memory contents: a recognisable function of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign Instruction  = imem(Address);
    assign Instruction2 = imem(Address2);

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PROG_END (PROG_END)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Freeze         (Freeze),
        .BranchTaken    (BranchTaken),
        .BranchAddr     (BranchAddr),
        .Address        (Address),
        .Instruction    (Instruction),
        .IF_Valid       (IF_Valid),
        .ID_Ready       (ID_Ready),
        .IF_Instruction (IF_Instruction),
        .IF_PC          (IF_PC),
        .Done           (Done)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount     (FetchCount),
        .StallCount     (StallCount)
`endif
    );

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PROG_END (32'h0000_0000)
    ) dut_z (
        .clk            (clk),
        .rst_n          (rst_n),
        .Freeze         (Freeze),
        .BranchTaken    (BranchTaken),
        .BranchAddr     (BranchAddr),
        .Address        (Address2),
        .Instruction    (Instruction2),
        .IF_Valid       (IF_Valid2),
        .ID_Ready       (ID_Ready),
        .IF_Instruction (IF_Instruction2),
        .IF_PC          (IF_PC2),
        .Done           (Done2)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount     (FetchCount2),
        .StallCount     (StallCount2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Tracks what the ports must show, straight from the fetch rules: the PC,
    // the output register contents and whether the program end was reached.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_ifpc;
    logic        m_done;
    logic        m_waiting;  // output full and decode refused last decision
    logic [31:0] m_fc;
    logic [31:0] m_sc;
    bit          m_take;

    always @(posedge clk) begin
        m_take = m_valid && ID_Ready;
        if (!rst_n) begin
            m_pc      = 32'h0;
            m_valid   = 1'b0;
            m_inst    = 32'h0;
            m_ifpc    = 32'h0;
            m_done    = 1'b0;
            m_waiting = 1'b0;
            m_fc      = 32'h0;
            m_sc      = 32'h0;
        end else begin
            if (m_waiting || Freeze) m_sc = m_sc + 32'd1;
            if (!BranchTaken && !Freeze && m_take) m_fc = m_fc + 32'd1;
            if (BranchTaken) begin
                m_pc      = BranchAddr & 32'hFFFF_FFFC;
                m_valid   = 1'b0;
                m_done    = 1'b0;
                m_waiting = 1'b0;
            end else if (!Freeze) begin
                if (m_done) begin
                    if (m_take) m_valid = 1'b0;
                end else if (!m_valid || ID_Ready) begin
                    m_inst    = imem(m_pc);
                    m_pc      = m_pc + 32'd4;
                    m_ifpc    = m_pc;
                    m_valid   = 1'b1;
                    m_done    = (m_pc == PROG_END);
                    m_waiting = 1'b0;
                end else begin
                    m_waiting = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------- compare process
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_address",  Address,        m_pc);
            check("cmp_if_valid", IF_Valid,       m_valid);
            check("cmp_if_inst",  IF_Instruction, m_inst);
            check("cmp_if_pc",    IF_PC,          m_ifpc);
            check("cmp_done",     Done,           m_done);
`ifdef FETCH_PERF_EN
            check("cmp_fetch_count", FetchCount, m_fc);
            check("cmp_stall_count", StallCount, m_sc);
`endif
            // Inputs are stable here, so this predicts a drain at the next edge.
            if (rst_n && !BranchTaken && !Freeze && IF_Valid && ID_Ready) begin
                xfer_log.push_back(IF_PC);
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic drive(input logic r, input logic f, input logic b,
                         input logic [31:0] ba, input logic rdy);
        rst_n       = r;
        Freeze      = f;
        BranchTaken = b;
        BranchAddr  = ba;
        ID_Ready    = rdy;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_log_sequence(input string name);
        check({name, "_count"}, xfer_log.size(), 32'd7);
        for (int i = 0; i < xfer_log.size() && i < 7; i++) begin
            check(name, xfer_log[i], 32'd4 * (i + 1));
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1);
        chk_en = 1;
        tick(1);

        // Reset state
        check("rst_address",  Address,        32'h0);
        check("rst_if_valid", IF_Valid,       32'h0);
        check("rst_if_inst",  IF_Instruction, 32'h0);
        check("rst_if_pc",    IF_PC,          32'h0);
        check("rst_done",     Done,           32'h0);

        // Straight run to program end
        xfer_log.delete();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1);
        check("run_first_if_pc", IF_PC,          32'h4);
        check("run_first_inst",  IF_Instruction, 32'hC0DE_0000);
        check("run_first_valid", IF_Valid,       32'h1);
        tick(6);
        check("run_done",        Done,           32'h1);
        check("run_end_address", Address,        32'h1C);
        check("run_last_if_pc",  IF_PC,          32'h1C);
        check("run_last_inst",   IF_Instruction, 32'hC0DE_0018);
        tick(1);
        check("run_drained",     IF_Valid,       32'h0);
        check("run_pc_held",     Address,        32'h1C);
        tick(1);
        check_log_sequence("run_xfer");

        // Backpressure for three cycles after the first valid
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1);
        xfer_log.delete();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("hold_address", Address,  32'h4);
            check("hold_if_pc",   IF_PC,    32'h4);
            check("hold_valid",   IF_Valid, 32'h1);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(8);
        check_log_sequence("hold_xfer");

        // Branch during Freeze: branch wins, target aligned, register flushed
        drive(1'b1, 1'b1, 1'b1, 32'h0000_000E, 1'b1);
        tick(1);
        check("brfrz_address", Address,  32'hC);
        check("brfrz_valid",   IF_Valid, 32'h0);
        check("brfrz_done",    Done,     32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        tick(2);
        check("frz_address",   Address,  32'hC);
        check("frz_valid",     IF_Valid, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick(2);
        check("brfetch_if_pc", IF_PC,          32'h10);
        check("brfetch_inst",  IF_Instruction, 32'hC0DE_000C);
        check("brfetch_addr",  Address,        32'h10);

        // Run to DONE, then restart with a branch to 0
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(4);
        check("done2_done",  Done,     32'h1);
        check("done2_valid", IF_Valid, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
        tick(1);
        check("restart_done",    Done,    32'h0);
        check("restart_address", Address, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1);
        check("restart_if_pc",   IF_PC,    32'h4);
        check("restart_valid",   IF_Valid, 32'h1);

        // Branch to the top of the address space: PC wraps to 0
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        tick(1);
        check("wrap_address",   Address,   32'hFFFF_FFFC);
        check("wrap_z_address", Address2,  32'hFFFF_FFFC);
        check("wrap_z_valid",   IF_Valid2, 32'h0);
        check("wrap_z_done",    Done2,     32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1);
        check("wrap_next_addr", Address,         32'h0);
        check("wrap_if_pc",     IF_PC,           32'h0);
        check("wrap_inst",      IF_Instruction,  32'h3F21_FFFC);
        check("wrap_z_addr",    Address2,        32'h0);
        check("wrap_z_done1",   Done2,           32'h1);
        check("wrap_z_if_pc",   IF_PC2,          32'h0);
        check("wrap_z_inst",    IF_Instruction2, 32'h3F21_FFFC);
        tick(1);
        check("wrap_z_drained", IF_Valid2,       32'h0);
        check("wrap_z_held",    Address2,        32'h0);
        check("wrap_z_done2",   Done2,           32'h1);

        // Reset while a transfer is pending: the word is dropped
        xfer_log.delete();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1);
        check("midrst_valid",   IF_Valid, 32'h0);
        check("midrst_address", Address,  32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1);
        check("midrst_xfers",   xfer_log.size(), 32'h0);
        check("midrst_if_pc",   IF_PC,           32'h4);
        check("midrst_inst",    IF_Instruction,  32'hC0DE_0000);

        // Two freeze cycles then five transfers
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        tick(2);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(6);
`ifdef FETCH_PERF_EN
        check("perf_fetch_count", FetchCount, 32'd5);
        check("perf_stall_count", StallCount, 32'd2);
`endif
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1);
`ifdef FETCH_PERF_EN
        check("perf_rst_fetch", FetchCount, 32'd0);
        check("perf_rst_stall", StallCount, 32'd0);
`endif
        check("final_valid", IF_Valid, 32'h0);
        tick(1);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, address of the first fetch after reset.
REQ-002 SHALL have parameter PROG_END, default 32'h0000001C, first address past the program; fetching stops on reaching it.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port Freeze, input, 1, hazard stall: hold PC and the output register.
REQ-006 SHALL have port BranchTaken, input, 1, redirect request from a later stage.
REQ-007 SHALL have port BranchAddr, input, 32, redirect target.
REQ-008 SHALL have port Address, output, 32, instruction memory address, equal to the PC register (combinational).
REQ-009 SHALL have port Instruction, input, 32, instruction memory read data, valid in the same cycle as Address.
REQ-010 SHALL have port IF_Valid, output, 1, IF_Instruction and IF_PC hold a live instruction.
REQ-011 SHALL have port ID_Ready, input, 1, decode accepts; transfer occurs when IF_Valid && ID_Ready.
REQ-012 SHALL have port IF_Instruction, output, 32, registered fetched instruction.
REQ-013 SHALL have port IF_PC, output, 32, registered address of the fetched instruction plus 4.
REQ-014 SHALL have port Done, output, 1, high while in state DONE.

Function
REQ-015 SHALL implement states RUN, HOLD and DONE.
REQ-016 In RUN, when the output register is empty or being drained (!IF_Valid || ID_Ready), the block SHALL load Instruction, load PC+4 into IF_PC, set IF_Valid, and advance PC by 4; latency from Address to IF_Valid is 1 cycle.
REQ-017 In RUN with IF_Valid && !ID_Ready, the block SHALL enter HOLD, holding PC and all outputs unchanged; it SHALL return to RUN in the cycle ID_Ready rises, performing that cycle's transfer and fetch.
REQ-018 When the advancing PC equals PROG_END, the block SHALL enter DONE: no further loads, PC held at PROG_END, IF_Valid cleared after its pending instruction transfers.
REQ-019 BranchTaken SHALL load PC with {BranchAddr[31:2],2'b00}, clear IF_Valid next cycle (flush), discard the current fetch, and move to RUN from any state, including DONE.
REQ-020 Freeze SHALL hold PC, state and outputs unchanged for as long as it is asserted.
REQ-021 Priority SHALL be rst_n low > BranchTaken > Freeze > handshake/advance.
REQ-022 PC arithmetic SHALL be modulo 2^32 (32'hFFFFFFFC + 4 = 32'h00000000).
REQ-023 Done SHALL be high in DONE only.

Reset
REQ-024 With rst_n low at a clock edge: PC = RESET_PC, state = RUN, IF_Valid = 0, IF_Instruction = 0, IF_PC = 0, Done = 0.
REQ-025 Reset asserted mid-transfer SHALL drop the pending instruction without a transfer; the first fetch after reset is at RESET_PC.

Configuration
REQ-026 With FETCH_PERF_EN defined, the block SHALL add outputs FetchCount[31:0] (count of completed transfers) and StallCount[31:0] (count of cycles in HOLD or with Freeze high), both reset to 0 and saturating at 32'hFFFFFFFF.
REQ-027 Without FETCH_PERF_EN, those ports and counters SHALL be absent.

Structure
REQ-028 A shared package SHALL hold INST_WIDTH (32), PC_STEP (4), the state encoding RUN/HOLD/DONE and the default RESET_PC.
REQ-029 The PC register with its increment, redirect and hold mux SHALL be a sub-module named pc_reg; the FSM and output register remain in fetch_unit.

Verification
REQ-030 Reset, then ID_Ready=1 with the instruction memory connected -> IF_PC = 4, 8, 12, ... on successive cycles; IF_Instruction matches each address; Done rises when PC = 32'h1C.
REQ-031 ID_Ready=0 for 3 cycles after the first valid -> outputs and Address stable for 3 cycles; no instruction lost or duplicated after release.
REQ-032 BranchTaken with BranchAddr=32'h0000000E while Freeze=1 -> next cycle Address = 32'h0000000C, IF_Valid = 0.
REQ-033 In DONE, BranchTaken with BranchAddr=0 -> Done falls and fetching restarts from 0.
REQ-034 Branch to 32'hFFFFFFFC with PROG_END=0 -> next fetch at 0 and the block enters DONE.
REQ-035 With FETCH_PERF_EN: 5 transfers and 2 freeze cycles -> FetchCount = 5, StallCount = 2; reset mid-run -> both counters 0.
